// File: rtl/note_sched_pkg.sv
// Shared types and constants for the note scheduler and its LRU tracker.
package note_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CONFIRM = 2'd2
  } state_e;

  // Wide enough to rank up to 8 voices
  localparam int RANK_W              = 3;
  localparam int DEF_CONFIRM_TIMEOUT = 4;

endpackage

// File: rtl/note_scheduler_voice_lru.sv
// Per-voice load-age ranks: rank 0 is the oldest load, NUM_VOICES-1 the newest.
import note_sched_pkg::*;

module voice_lru #(
  parameter int NUM_VOICES = 3,
  parameter int TGT_W      = $clog2(NUM_VOICES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_upd,
  input  logic [TGT_W-1:0] i_tgt,
  output logic [TGT_W-1:0] o_oldest
);

  logic [NUM_VOICES-1:0][RANK_W-1:0] r_rank;
  logic [RANK_W-1:0]                 w_tgt_rank;

  assign w_tgt_rank = r_rank[i_tgt];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= RANK_W'(i);
    end else if (i_upd) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (TGT_W'(i) == i_tgt)
          r_rank[i] <= RANK_W'(NUM_VOICES - 1);
        else if (r_rank[i] > w_tgt_rank)
          r_rank[i] <= r_rank[i] - RANK_W'(1);
      end
    end
  end

  // Ranks are a permutation, so exactly one voice holds rank 0
  always_comb begin
    o_oldest = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (r_rank[i] == '0) o_oldest = TGT_W'(i);
  end

endmodule

// File: rtl/note_scheduler.sv
// Schedules incoming notes onto free note-player voices with load confirmation.
// Optional voice stealing of the least-recently-loaded voice: NOTE_SCHED_STEAL_EN.
import note_sched_pkg::*;

module note_scheduler #(
  parameter int NUM_VOICES      = 3,
  parameter int CONFIRM_TIMEOUT = DEF_CONFIRM_TIMEOUT
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_play,
  input  logic                            i_note_valid,
  output logic                            o_note_ready,
  input  logic [5:0]                      i_note_in,
  input  logic [5:0]                      i_duration_in,
  input  logic [NUM_VOICES-1:0]           i_voice_playing,
  output logic [NUM_VOICES-1:0]           o_voice_load,
  output logic [5:0]                      o_voice_note,
  output logic [5:0]                      o_voice_duration,
  output logic [$clog2(NUM_VOICES+1)-1:0] o_active_count,
  output logic                            o_note_dropped
);

  localparam int TGT_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(CONFIRM_TIMEOUT + 1);
  localparam int ACT_W = $clog2(NUM_VOICES + 1);

  state_e           r_state;
  logic [TGT_W-1:0] r_tgt;
  logic [CNT_W-1:0] r_tmr;
  logic [5:0]       r_note;
  logic [5:0]       r_dur;
  logic             r_dropped;

  logic [NUM_VOICES-1:0] w_tgt_oh;
  logic [NUM_VOICES-1:0] w_resv;
  logic [NUM_VOICES-1:0] w_free;
  logic [NUM_VOICES-1:0] w_busy;
  logic [TGT_W-1:0]      w_free_idx;
  logic [TGT_W-1:0]      w_sel;
  logic                  w_found;
  logic                  w_avail;
  logic                  w_accept;
  logic                  w_tgt_play;

  assign w_tgt_oh   = NUM_VOICES'(1) << r_tgt;
  assign w_resv     = (r_state != ST_IDLE) ? w_tgt_oh : '0;
  assign w_busy     = i_voice_playing | w_resv;
  assign w_free     = ~w_busy;
  assign w_tgt_play = |(i_voice_playing & w_tgt_oh);

  // Lowest free index wins; playing status is sampled live so a voice freeing this cycle counts
  always_comb begin
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_found    = 1'b1;
        w_free_idx = TGT_W'(i);
      end
    end
  end

`ifdef NOTE_SCHED_STEAL_EN
  logic [TGT_W-1:0] w_oldest;

  voice_lru #(.NUM_VOICES(NUM_VOICES), .TGT_W(TGT_W)) u_lru (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_upd    (r_state == ST_ISSUE),
    .i_tgt    (r_tgt),
    .o_oldest (w_oldest)
  );

  assign w_avail = 1'b1;
  assign w_sel   = w_found ? w_free_idx : w_oldest;
`else
  assign w_avail = w_found;
  assign w_sel   = w_free_idx;
`endif

  assign o_note_ready = (r_state == ST_IDLE) && i_play && w_avail;
  assign w_accept     = o_note_ready && i_note_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_tgt     <= '0;
      r_tmr     <= '0;
      r_note    <= '0;
      r_dur     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_note  <= i_note_in;
            r_dur   <= i_duration_in;
            r_tgt   <= w_sel;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmr   <= '0;
          r_state <= ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (w_tgt_play) begin
            r_state <= ST_IDLE;
          end else if (r_tmr == CNT_W'(CONFIRM_TIMEOUT - 1)) begin
            r_dropped <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      o_active_count = o_active_count + ACT_W'(w_busy[i]);
  end

  assign o_voice_load     = (r_state == ST_ISSUE) ? w_tgt_oh : '0;
  assign o_voice_note     = r_note;
  assign o_voice_duration = r_dur;
  assign o_note_dropped   = r_dropped;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler (3 voices, confirm timeout 4).
module tb_note_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       note_valid;
  logic       note_ready;
  logic [5:0] note_in;
  logic [5:0] duration_in;
  logic [2:0] voice_playing;
  logic [2:0] voice_load;
  logic [5:0] voice_note;
  logic [5:0] voice_duration;
  logic [1:0] active_count;
  logic       note_dropped;

  int n_run  = 0;
  int n_fail = 0;

  note_scheduler #(.NUM_VOICES(3), .CONFIRM_TIMEOUT(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_play           (play),
    .i_note_valid     (note_valid),
    .o_note_ready     (note_ready),
    .i_note_in        (note_in),
    .i_duration_in    (duration_in),
    .i_voice_playing  (voice_playing),
    .o_voice_load     (voice_load),
    .o_voice_note     (voice_note),
    .o_voice_duration (voice_duration),
    .o_active_count   (active_count),
    .o_note_dropped   (note_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let combinational outputs settle before checks
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; note_valid = 1'b0;
    note_in = '0; duration_in = '0; voice_playing = '0;
    do_reset();

    // Reset state
    chk("rst_load",  voice_load, 0);
    chk("rst_note",  voice_note, 0);
    chk("rst_dur",   voice_duration, 0);
    chk("rst_drop",  note_dropped, 0);
    chk("rst_act",   active_count, 0);
    chk("rst_ready", note_ready, 0);

    // First note lands on voice 0 one cycle after acceptance
    play = 1'b1; note_valid = 1'b1; note_in = 6'd12; duration_in = 6'd8;
    #1 chk("n1_ready", note_ready, 1);
    cyc();
    note_valid = 1'b0;
    chk("n1_load",  voice_load, 3'b001);
    chk("n1_note",  voice_note, 12);
    chk("n1_dur",   voice_duration, 8);
    chk("n1_act",   active_count, 1);
    chk("n1_busy",  note_ready, 0);
    cyc();
    chk("n1_load_off", voice_load, 0);
    voice_playing = 3'b001;
    cyc();
    chk("n1_idle", note_ready, 1);
    chk("n1_act2", active_count, 1);

    // Voices 0,1 busy: next goes to voice 2, ready held low until it plays
    voice_playing = 3'b011; note_valid = 1'b1; note_in = 6'd5; duration_in = 6'd3;
    cyc();
    note_valid = 1'b0;
    chk("n2_load", voice_load, 3'b100);
    chk("n2_act",  active_count, 3);
    cyc();
    chk("n2_ready_c0", note_ready, 0);
    chk("n2_note_hold", voice_note, 5);
    cyc();
    chk("n2_ready_c1", note_ready, 0);
    voice_playing = 3'b111;
    cyc();
    chk("n2_act3", active_count, 3);
    chk("n2_nodrop", note_dropped, 0);

`ifndef NOTE_SCHED_STEAL_EN
    // All playing: blocked; freeing voice 1 makes it the next target
    note_valid = 1'b1; note_in = 6'd7; duration_in = 6'd9;
    #1 chk("full_ready", note_ready, 0);
    cyc();
    chk("full_noload", voice_load, 0);
    chk("full_ready2", note_ready, 0);
    voice_playing = 3'b101;
    #1 chk("free1_ready", note_ready, 1);
    chk("free1_act", active_count, 2);
    cyc();
    note_valid = 1'b0;
    chk("free1_load", voice_load, 3'b010);
    voice_playing = 3'b111;
    cyc();
    cyc();
`endif

    // Timeout: voice 0 never confirms, drop pulse 5 cycles after the load
    voice_playing = 3'b000; note_valid = 1'b1; note_in = 6'd33; duration_in = 6'd44;
    cyc();
    note_valid = 1'b0;
    chk("to_load", voice_load, 3'b001);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("to_nodrop%0d", k), note_dropped, 0);
    end
    cyc();
    chk("to_drop", note_dropped, 1);
    chk("to_ready", note_ready, 1);
    chk("to_act", active_count, 0);
    cyc();
    chk("to_drop_once", note_dropped, 0);
    note_valid = 1'b1; note_in = 6'd1; duration_in = 6'd2;
    cyc();
    note_valid = 1'b0;
    chk("to_reload", voice_load, 3'b001);
    voice_playing = 3'b001;
    cyc();
    cyc();
    voice_playing = 3'b000;

    // play=0 blocks acceptance
    play = 1'b0; note_valid = 1'b1; note_in = 6'd20; duration_in = 6'd21;
    #1 chk("p0_ready", note_ready, 0);
    cyc();
    chk("p0_noload", voice_load, 0);

    // Reset mid-CONFIRM aborts silently
    play = 1'b1;
    cyc();
    note_valid = 1'b0;
    chk("rc_load", voice_load, 3'b001);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rc_note", voice_note, 0);
    chk("rc_dur",  voice_duration, 0);
    chk("rc_load0", voice_load, 0);
    chk("rc_act",  active_count, 0);
    chk("rc_ready", note_ready, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rc_nodrop%0d", k), note_dropped, 0);
      cyc();
    end

`ifdef NOTE_SCHED_STEAL_EN
    // Steal: after loading 0,1,2 the LRU order returns voice 0 then voice 1
    do_reset();
    play = 1'b1;
    for (int v = 0; v < 3; v++) begin
      note_valid = 1'b1; note_in = 6'(v + 1); duration_in = 6'd4;
      cyc();
      note_valid = 1'b0;
      chk($sformatf("st_fill%0d", v), voice_load, 3'b001 << v);
      voice_playing = voice_playing | (3'b001 << v);
      cyc();
      cyc();
    end
    note_valid = 1'b1;
    #1 chk("st_ready", note_ready, 1);
    cyc();
    note_valid = 1'b0;
    chk("st_4th", voice_load, 3'b001);
    cyc();
    cyc();
    chk("st_4th_done", note_ready, 1);
    note_valid = 1'b1;
    cyc();
    note_valid = 1'b0;
    chk("st_5th", voice_load, 3'b010);
    cyc();
    cyc();
    chk("st_nodrop", note_dropped, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
